// File: rtl/par_to_serial_tx_if.sv
// Upstream byte stream into the serializer: data/valid forward, ready back.
interface par_to_serial_tx_if #(
  parameter int unsigned DATA_W = 8
) ();
  logic [DATA_W-1:0] dataIn;
  logic              validIn;
  logic              readyOut;

  modport master (output dataIn, output validIn, input readyOut);
  modport slave  (input dataIn, input validIn, output readyOut);
endinterface

// File: rtl/par_to_serial_tx.sv
// Buffers upstream bytes in a small FIFO and shifts them out MSB-first, one bit per clk,
// sending IDLE_SYM on a fixed DATA_W-cycle symbol cadence whenever no byte is queued.
module par_to_serial_tx #(
  parameter int unsigned       DATA_W     = 8,
  parameter logic [DATA_W-1:0] IDLE_SYM   = 8'hBC,
  parameter int unsigned       FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  par_to_serial_tx_if.slave             up,
  output logic                          serialOut,
  output logic                          syncOut,
  output logic                          activeOut,
  output logic [$clog2(FIFO_DEPTH):0]   fifoLevel
);

  localparam int unsigned CntW = $clog2(DATA_W);
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned LvlW = PtrW + 1;
  localparam logic [CntW-1:0] LastBit = CntW'(DATA_W - 1);
  localparam logic [LvlW-1:0] FullLvl = LvlW'(FIFO_DEPTH);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [DATA_W-1:0] shiftRegQ, shiftRegD;
  logic [CntW-1:0]   bitCntQ, bitCntD;
  logic              activeQ, activeD;
  logic [PtrW-1:0]   wrPtrQ, wrPtrD;
  logic [PtrW-1:0]   rdPtrQ, rdPtrD;
  logic [LvlW-1:0]   countQ, countD;

  logic ready;
  logic push;
  logic boundary;
  logic pop;

  // Ready depends only on the registered count, so a same-edge pop never frees a slot.
  assign ready       = (countQ != FullLvl);
  assign up.readyOut = ready;
  assign push        = up.validIn && ready;
  assign boundary    = (bitCntQ == LastBit);
  assign pop         = boundary && (countQ != '0);

  always_comb begin
    shiftRegD = {shiftRegQ[DATA_W-2:0], 1'b0};
    bitCntD   = bitCntQ + CntW'(1);
    activeD   = activeQ;
    wrPtrD    = wrPtrQ;
    rdPtrD    = rdPtrQ;
    countD    = countQ;

    if (boundary) begin
      bitCntD = '0;
      if (pop) begin
        shiftRegD = mem[rdPtrQ];
        activeD   = 1'b1;
      end else begin
        shiftRegD = IDLE_SYM;
        activeD   = 1'b0;
      end
    end

    // Depth is a power of two, so pointers wrap by natural overflow.
    if (push) wrPtrD = wrPtrQ + PtrW'(1);
    if (pop)  rdPtrD = rdPtrQ + PtrW'(1);

    case ({push, pop})
      2'b10:   countD = countQ + LvlW'(1);
      2'b01:   countD = countQ - LvlW'(1);
      default: countD = countQ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shiftRegQ <= IDLE_SYM;
      bitCntQ   <= '0;
      activeQ   <= 1'b0;
      wrPtrQ    <= '0;
      rdPtrQ    <= '0;
      countQ    <= '0;
    end else begin
      shiftRegQ <= shiftRegD;
      bitCntQ   <= bitCntD;
      activeQ   <= activeD;
      wrPtrQ    <= wrPtrD;
      rdPtrQ    <= rdPtrD;
      countQ    <= countD;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem[i] <= '0;
    end else if (push) begin
      mem[wrPtrQ] <= up.dataIn;
    end
  end

  assign serialOut = shiftRegQ[DATA_W-1];
  assign syncOut   = (bitCntQ == '0);
  assign activeOut = activeQ;
  assign fifoLevel = countQ;

endmodule
